vector_aggregate_accumulator: RTL and testbench

- Consumer end of the vector-add datapath. Accepts a valid/ready stream of WEIGHT_COLS-element vectors, one vector per beat, and sums them element-wise into one running vector.
- Each group of beats is one node's neighbourhood, closed by in_last. When a group closes, the block presents the aggregated vector and the group's beat count on a valid/ready output.
- Sits between the feature-transform stage and the output feature buffer of the GCN aggregation path.

---
 rtl/gcn_pkg.sv | 22 ++
 rtl/Vector_Adder_3.sv | 20 ++
 rtl/vector_aggregate_accumulator.sv | 136 +++++++++++++
 tb/tb_vector_aggregate_accumulator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gcn_pkg : shared types and defaults for the GCN aggregation path      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package gcn_pkg;

    localparam int WEIGHT_COLS    = 3;
    localparam int DOT_PROD_WIDTH = 16;
    localparam int COUNT_WIDTH    = 8;

    typedef logic [DOT_PROD_WIDTH-1:0] elem_t;
    typedef elem_t vec_t [0:WEIGHT_COLS-1];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } agg_state_t;

endpackage
`default_nettype wire

// File: rtl/Vector_Adder_3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Vector_Adder_3 : combinational element-wise modular vector adder      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module Vector_Adder_3 #(
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16
) (
    input  logic [DOT_PROD_WIDTH-1:0] i_a   [0:WEIGHT_COLS-1],
    input  logic [DOT_PROD_WIDTH-1:0] i_b   [0:WEIGHT_COLS-1],
    output logic [DOT_PROD_WIDTH-1:0] o_sum [0:WEIGHT_COLS-1]
);

    for (genvar g = 0; g < WEIGHT_COLS; g++) begin : g_elem
        assign o_sum[g] = i_a[g] + i_b[g];
    end

endmodule
`default_nettype wire

// File: rtl/vector_aggregate_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_aggregate_accumulator : sums a stream of vectors per group and |
// | presents the aggregate with its beat count.   Rev 1.0                 |
// +----------------------------------------------------------------------+
module vector_aggregate_accumulator #(
    parameter int WEIGHT_COLS    = gcn_pkg::WEIGHT_COLS,
    parameter int DOT_PROD_WIDTH = gcn_pkg::DOT_PROD_WIDTH,
    parameter int COUNT_WIDTH    = gcn_pkg::COUNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DOT_PROD_WIDTH-1:0] in_vec  [0:WEIGHT_COLS-1],
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [DOT_PROD_WIDTH-1:0] out_vec [0:WEIGHT_COLS-1],
    output logic [COUNT_WIDTH-1:0]    out_count,
    output logic                      out_overflow,
    output logic                      out_valid,
    input  logic                      out_ready
);
    import gcn_pkg::*;

    localparam logic [COUNT_WIDTH-1:0] C_COUNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] C_COUNT_MAX = '1;

    agg_state_t                r_state;
    agg_state_t                w_next_state;
    logic [DOT_PROD_WIDTH-1:0] r_acc      [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] w_sum      [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] w_acc_next [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] r_out_vec  [0:WEIGHT_COLS-1];
    logic [COUNT_WIDTH-1:0]    r_count;
    logic [COUNT_WIDTH-1:0]    w_count_next;
    logic [COUNT_WIDTH-1:0]    r_out_count;
    logic                      r_ovf;
    logic                      w_ovf_next;
    logic                      r_out_ovf;
    logic                      r_out_valid;
    logic                      w_accept;
    logic                      w_carry;
    logic                      w_sat;

    Vector_Adder_3 #(
        .WEIGHT_COLS    (WEIGHT_COLS),
        .DOT_PROD_WIDTH (DOT_PROD_WIDTH)
    ) u_adder (
        .i_a   (r_acc),
        .i_b   (in_vec),
        .o_sum (w_sum)
    );

    assign in_ready     = (r_state != HOLD);
    assign w_accept     = in_valid && in_ready;
    assign out_vec      = r_out_vec;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_ovf;
    assign out_valid    = r_out_valid;

    // A modular sum smaller than its operand means that element wrapped.
    always_comb begin
        w_carry = 1'b0;
        for (int i = 0; i < WEIGHT_COLS; i++) begin
            if (w_sum[i] < r_acc[i]) begin
                w_carry = 1'b1;
            end
        end
        w_sat = (r_count == C_COUNT_MAX);
    end

    always_comb begin
        w_acc_next   = w_sum;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        if (r_state == IDLE) begin
            w_acc_next   = in_vec;
            w_count_next = C_COUNT_ONE;
            w_ovf_next   = 1'b0;
        end else begin
            w_count_next = w_sat ? r_count : r_count + C_COUNT_ONE;
            w_ovf_next   = r_ovf | w_carry | w_sat;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = in_last ? HOLD : ACCUM;
            ACCUM:   if (w_accept && in_last) w_next_state = HOLD;
            HOLD:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < WEIGHT_COLS; i++) begin
                r_acc[i]     <= '0;
                r_out_vec[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_count <= w_count_next;
                r_ovf   <= w_ovf_next;
                for (int i = 0; i < WEIGHT_COLS; i++) begin
                    r_acc[i] <= w_acc_next[i];
                end
                if (in_last) begin
                    r_out_count <= w_count_next;
                    r_out_ovf   <= w_ovf_next;
                    r_out_valid <= 1'b1;
                    for (int i = 0; i < WEIGHT_COLS; i++) begin
                        r_out_vec[i] <= w_acc_next[i];
                    end
                end
            end else if ((r_state == HOLD) && out_ready) begin
                r_count     <= '0;
                r_ovf       <= 1'b0;
                r_out_valid <= 1'b0;
                for (int i = 0; i < WEIGHT_COLS; i++) begin
                    r_acc[i] <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_aggregate_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vector_aggregate_accumulator : directed self-checking bench        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_vector_aggregate_accumulator;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_vec [0:2];
    logic        in_valid_a;
    logic        in_valid_b;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a;
    logic [15:0] out_vec_a [0:2];
    logic [7:0]  out_count_a;
    logic        out_overflow_a;
    logic        out_valid_a;

    logic        in_ready_b;
    logic [15:0] out_vec_b [0:2];
    logic [1:0]  out_count_b;
    logic        out_overflow_b;
    logic        out_valid_b;

    int n_checks;
    int n_errors;

    vector_aggregate_accumulator dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vec       (in_vec),
        .in_valid     (in_valid_a),
        .in_last      (in_last),
        .in_ready     (in_ready_a),
        .out_vec      (out_vec_a),
        .out_count    (out_count_a),
        .out_overflow (out_overflow_a),
        .out_valid    (out_valid_a),
        .out_ready    (out_ready)
    );

    vector_aggregate_accumulator #(.COUNT_WIDTH(2)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vec       (in_vec),
        .in_valid     (in_valid_b),
        .in_last      (in_last),
        .in_ready     (in_ready_b),
        .out_vec      (out_vec_b),
        .out_count    (out_count_b),
        .out_overflow (out_overflow_b),
        .out_valid    (out_valid_b),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit sel, input int a, input int b, input int c, input bit last);
        int n = 0;
        in_vec[0] = 16'(a);
        in_vec[1] = 16'(b);
        in_vec[2] = 16'(c);
        in_last   = last;
        if (sel) in_valid_b = 1'b1;
        else     in_valid_a = 1'b1;
        while (!(sel ? in_ready_b : in_ready_a) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic check_a(input string tag, input int v0, input int v1, input int v2,
                           input int cnt, input bit ovf);
        check({tag, "_valid"}, 32'(out_valid_a), 32'd1);
        check({tag, "_v0"}, 32'(out_vec_a[0]), 32'(v0));
        check({tag, "_v1"}, 32'(out_vec_a[1]), 32'(v1));
        check({tag, "_v2"}, 32'(out_vec_a[2]), 32'(v2));
        check({tag, "_cnt"}, 32'(out_count_a), 32'(cnt));
        check({tag, "_ovf"}, 32'(out_overflow_a), 32'(ovf));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_valid_a", 32'(out_valid_a), 32'd0);
        check("drain_ready_a", 32'(in_ready_a), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 3; i++) in_vec[i] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_valid", 32'(out_valid_a), 32'd0);
        check("rst_ready", 32'(in_ready_a), 32'd1);
        check("rst_vec0", 32'(out_vec_a[0]), 32'd0);
        check("rst_count", 32'(out_count_a), 32'd0);
        check("rst_ovf", 32'(out_overflow_a), 32'd0);

        // three-beat group
        beat(0, 1, 2, 3, 0);
        check("g3_mid_valid", 32'(out_valid_a), 32'd0);
        beat(0, 10, 20, 30, 0);
        beat(0, 100, 200, 300, 1);
        check_a("g3", 111, 222, 333, 3, 0);
        drain();

        // single beat held by backpressure
        beat(0, 7, 0, 65535, 1);
        for (int k = 0; k < 4; k++) begin
            check_a("hold", 7, 0, 65535, 1, 0);
            check("hold_in_ready", 32'(in_ready_a), 32'd0);
            tick();
        end
        drain();

        // element wrap
        beat(0, 65535, 1, 0, 0);
        beat(0, 2, 1, 0, 1);
        check_a("wrap", 1, 2, 0, 2, 1);
        drain();

        // gappy group
        beat(0, 5, 5, 5, 0);
        for (int k = 0; k < 3; k++) begin
            check("gap_valid", 32'(out_valid_a), 32'd0);
            tick();
        end
        beat(0, 5, 5, 5, 1);
        check_a("gappy", 10, 10, 10, 2, 0);
        drain();

        // count saturation on the 2-bit counter instance
        for (int k = 0; k < 5; k++) beat(1, 1, 1, 1, k == 4);
        check("sat_valid", 32'(out_valid_b), 32'd1);
        check("sat_v0", 32'(out_vec_b[0]), 32'd5);
        check("sat_v2", 32'(out_vec_b[2]), 32'd5);
        check("sat_cnt", 32'(out_count_b), 32'd3);
        check("sat_ovf", 32'(out_overflow_b), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sat_drain", 32'(out_valid_b), 32'd0);

        // reset mid-group discards the partial sum
        beat(0, 9, 9, 9, 0);
        beat(0, 9, 9, 9, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_valid", 32'(out_valid_a), 32'd0);
        check("abort_ready", 32'(in_ready_a), 32'd1);
        tick();
        check("abort_idle_valid", 32'(out_valid_a), 32'd0);
        beat(0, 4, 4, 4, 1);
        check_a("post_rst", 4, 4, 4, 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
